pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 94 +++++++++
 tb/tb_pipelined_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Carry-skewed pipelined adder/subtractor: each stage resolves one C-bit chunk
// and passes its carry on; one global enable advances or freezes the whole pipe.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int C = WIDTH / STAGES;

    logic [WIDTH-1:0] a_q       [STAGES];
    logic [WIDTH-1:0] b_q       [STAGES];
    logic [WIDTH-1:0] sum_q     [STAGES];
    logic             carry_q   [STAGES];
    logic             valid_q   [STAGES];

    logic [WIDTH-1:0] aIn       [STAGES];
    logic [WIDTH-1:0] bIn       [STAGES];
    logic [WIDTH-1:0] sumIn     [STAGES];
    logic             carryIn   [STAGES];
    logic             validIn   [STAGES];
    logic [WIDTH-1:0] sum_d     [STAGES];
    logic             carry_d   [STAGES];
    logic [C:0]       chunk;
    logic             en;

    assign en       = !valid_q[STAGES-1] || out_ready;
    assign in_ready = en;

    // Stage 0 sees the ports (with subtraction folded into B' and carry-in);
    // every later stage sees the skew registers of the stage before it.
    always_comb begin
        chunk      = '0;
        aIn[0]     = a;
        bIn[0]     = sub ? ~b : b;
        sumIn[0]   = '0;
        carryIn[0] = sub ? 1'b1 : cin;
        validIn[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            aIn[k]     = a_q[k-1];
            bIn[k]     = b_q[k-1];
            sumIn[k]   = sum_q[k-1];
            carryIn[k] = carry_q[k-1];
            validIn[k] = valid_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, aIn[k][k*C +: C]} + {1'b0, bIn[k][k*C +: C]}
                  + (C+1)'(carryIn[k]);
            sum_d[k]              = sumIn[k];
            sum_d[k][k*C +: C]    = chunk[C-1:0];
            carry_d[k]            = chunk[C];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= aIn[k];
                b_q[k]     <= bIn[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= validIn[k];
            end
        end
    end

    // Overflow uses the operand sign bits carried to the last stage.
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                    && (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streaming bench for pipelined_adder, plus exhaustive 4-bit runs
// of the single-stage and fully-pipelined configurations.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        sValid;
    logic [3:0]  sA;
    logic [3:0]  sB;
    logic        sCin;
    logic        sSub;
    logic        sReady;
    logic        ready1, valid1, cout1, ovf1;
    logic        ready4, valid4, cout4, ovf4;
    logic [3:0]  sum1, sum4;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vecT;

    vecT tbl [9];

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(4), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sValid), .in_ready(ready1),
        .a(sA), .b(sB), .cin(sCin), .sub(sSub), .out_valid(valid1),
        .out_ready(sReady), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    pipelined_adder #(.WIDTH(4), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sValid), .in_ready(ready4),
        .a(sA), .b(sB), .cin(sCin), .sub(sSub), .out_valid(valid4),
        .out_ready(sReady), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference result {ovf, cout, sum} for a w-bit add/subtract.
    function automatic logic [17:0] refAdd(input int w, input logic [15:0] x,
                                           input logic [15:0] y, input logic c,
                                           input logic s);
        logic [16:0] mask;
        logic [15:0] xm, ye;
        logic [16:0] full;
        logic        co, ov;
        mask = (17'd1 << w) - 17'd1;
        xm   = x & mask[15:0];
        ye   = (s ? ~y : y) & mask[15:0];
        full = {1'b0, xm} + {1'b0, ye} + (s ? 17'd1 : {16'd0, c});
        co   = full[w];
        ov   = (xm[w-1] == ye[w-1]) && (full[w-1] != xm[w-1]);
        return {ov, co, full[15:0] & mask[15:0]};
    endfunction

    // Sends one operand set on an idle pipe and checks latency and result.
    task automatic applyStimulus(input vecT v, input string tag);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        #1;
        checkOutput({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, lat, 4);
        checkOutput({tag, " sum"}, sum, v.s);
        checkOutput({tag, " cout"}, cout, v.co);
        checkOutput({tag, " ovf"}, ovf, v.ov);
    endtask

    initial begin
        logic [17:0] expQ [$];
        logic [17:0] expV, holdVal;
        logic        holdValid, needNew;
        int          sent, got, validCount;

        tbl[0] = {16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = {16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = {16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[4] = {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = {16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[6] = {16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[7] = {16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[8] = {16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        sValid = 1'b0; sA = '0; sB = '0; sCin = 1'b0; sSub = 1'b0; sReady = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset sum", sum, 0);
        checkOutput("reset cout", cout, 0);
        checkOutput("reset ovf", ovf, 0);
        checkOutput("reset in_ready", in_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

        // Random back-to-back stream with a randomly stalling consumer.
        sent = 0; got = 0; holdValid = 1'b0; holdVal = '0; needNew = 1'b1;
        for (int cyc = 0; cyc < 2000 && got < 32; cyc++) begin
            @(negedge clk);
            if (needNew) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            in_valid  = (sent < 32);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            checkOutput("in_ready==en", in_ready, !out_valid || out_ready);
            if (holdValid)
                checkOutput("stall hold", {out_valid, ovf, cout, sum}, {1'b1, holdVal});
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) checkOutput("stream extra result", 1, 0);
                else begin
                    expV = expQ.pop_front();
                    checkOutput($sformatf("stream res%0d", got), {ovf, cout, sum}, expV);
                end
                got++;
            end
            holdValid = out_valid && !out_ready;
            holdVal   = {ovf, cout, sum};
            if (in_valid && in_ready) begin
                expQ.push_back(refAdd(16, a, b, cin, sub));
                sent++;
                needNew = 1'b1;
            end else begin
                needNew = 1'b0;
            end
        end
        in_valid = 1'b0;
        checkOutput("stream count", got, 32);

        // Three transactions in flight, then an asynchronous reset mid-cycle.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h0100 * 16'(i + 1); b = 16'h0011; cin = 1'b0; sub = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("preload out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async rst out_valid", out_valid, 0);
        checkOutput("async rst result", {ovf, cout, sum}, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        validCount = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge clk);
            if (out_valid) begin
                validCount++;
                checkOutput("post-reset latency", n, 4);
                checkOutput("post-reset result", {ovf, cout, sum}, 18'h03333);
            end
        end
        checkOutput("no stale results", validCount, 1);

        // Exhaustive 4-bit sweep: vector j is driven at negedge j, so the
        // latency-L instance must show vector m-L at negedge m.
        for (int m = 0; m < 1024 + 5; m++) begin
            @(negedge clk);
            if (m < 1024) begin
                sValid = 1'b1;
                {sSub, sCin, sA, sB} = 10'(m);
            end else begin
                sValid = 1'b0;
            end
            #1;
            if (m >= 1 && m - 1 < 1024) begin
                logic [9:0] v1;
                v1   = 10'(m - 1);
                expV = refAdd(4, {12'd0, v1[7:4]}, {12'd0, v1[3:0]}, v1[8], v1[9]);
                checkOutput("ex W4S1", {valid1, ovf1, cout1, sum1}, {1'b1, expV[17:16], expV[3:0]});
            end else begin
                checkOutput("ex W4S1 valid", valid1, 0);
            end
            if (m >= 4 && m - 4 < 1024) begin
                logic [9:0] v4;
                v4   = 10'(m - 4);
                expV = refAdd(4, {12'd0, v4[7:4]}, {12'd0, v4[3:0]}, v4[8], v4[9]);
                checkOutput("ex W4S4", {valid4, ovf4, cout4, sum4}, {1'b1, expV[17:16], expV[3:0]});
            end else begin
                checkOutput("ex W4S4 valid", valid4, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
